// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Package : trap_pkg
// Purpose : Shared constants and types for the machine-mode trap/return logic.
//           This package holds the data width, the return-sequencer state
//           encoding and the CSR addresses of MEPC and MSTATUS.
// Rev     : 1.0  initial release
// ============================================================================
package trap_pkg;

   localparam int XLEN = 32;

   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      REDIRECT = 2'd2
   } ret_state_e;

endpackage
`default_nettype wire

// File: rtl/ret_event_counter.sv
`default_nettype none
// ============================================================================
// Module  : ret_event_counter
// Purpose : Free-running event counter. It advances by one on each cycle that
//           inc_in is high and wraps from all-ones to zero.
// Ports   : clk_in    - clock
//           rst_n_in  - asynchronous active-low reset (clears the count)
//           inc_in    - count this cycle
//           count_out - current count
// Rev     : 1.0  initial release
// ============================================================================
module ret_event_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             inc_in,
   output logic [WIDTH-1:0] count_out
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Natural modulo-2^WIDTH arithmetic gives the wrap to zero.
   always_comb begin
      count_d = count_q;
      if (inc_in) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;

endmodule
`default_nettype wire

// File: rtl/mret_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mret_return_ctrl
// Purpose : Trap-return sequencer. When an MRET is accepted, the block latches
//           the word-aligned MEPC and then flushes the pipeline until it is
//           empty. On entry to the redirect phase it pulses the MSTATUS
//           restore strobe once. It then holds the return PC to fetch until
//           fetch accepts it.
// Ports   : clk_in, rst_n_in       - clock, async active-low reset
//           mret_in                - committed MRET from decode
//           trap_pending_in        - trap entry this cycle (wins / aborts)
//           mepc_in                - current MEPC value
//           pipe_empty_in          - no older instructions in flight
//           redirect_ready_in      - fetch accepts the redirect
//           busy_out               - sequencer active (decode stall)
//           flush_out              - flush younger stages
//           mstatus_restore_out    - one-cycle MIE<-MPIE, MPIE<-1 strobe
//           redirect_valid_out     - return PC valid
//           redirect_pc_out        - return PC
//           ret_count_out          - completed-return count
// Config  : RET_COUNT_EN - when defined, counts redirect handshakes in
//           ret_count_out. When undefined, ret_count_out is tied to zero.
// Rev     : 1.0  initial release
// ============================================================================
module mret_return_ctrl #(
   parameter int               XLEN     = trap_pkg::XLEN,
   parameter logic [XLEN-1:0]  PC_RESET = '0
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            mret_in,
   input  logic            trap_pending_in,
   input  logic [XLEN-1:0] mepc_in,
   input  logic            pipe_empty_in,
   input  logic            redirect_ready_in,
   output logic            busy_out,
   output logic            flush_out,
   output logic            mstatus_restore_out,
   output logic            redirect_valid_out,
   output logic [XLEN-1:0] redirect_pc_out,
   output logic [31:0]     ret_count_out
);

   import trap_pkg::*;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   ret_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            restore_q, restore_d;
   logic            handshake;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      restore_d = 1'b0;
      case (state_q)
         IDLE: begin
            // A simultaneous trap entry takes priority and the MRET is dropped.
            if (mret_in && !trap_pending_in) begin
               state_d = DRAIN;
               pc_d    = mepc_in & ALIGN_MASK;
            end
         end
         DRAIN: begin
            if (trap_pending_in) begin
               state_d = IDLE;
            end else if (pipe_empty_in) begin
               state_d   = REDIRECT;
               restore_d = 1'b1;
            end
         end
         REDIRECT: begin
            // The return is committed here, so trap_pending_in is ignored.
            if (redirect_ready_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         pc_q      <= PC_RESET;
         restore_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         restore_q <= restore_d;
      end
   end

   assign busy_out            = (state_q != IDLE);
   assign flush_out           = (state_q == DRAIN);
   assign redirect_valid_out  = (state_q == REDIRECT);
   assign redirect_pc_out     = pc_q;
   assign mstatus_restore_out = restore_q;
   assign handshake           = redirect_valid_out && redirect_ready_in;

`ifdef RET_COUNT_EN
   ret_event_counter #(
      .WIDTH (32)
   ) u_ret_event_counter (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .inc_in    (handshake),
      .count_out (ret_count_out)
   );
`else
   assign ret_count_out = 32'd0;
`endif

endmodule
`default_nettype wire
